pipe_ctrl_unit: RTL
===================

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter MULDIV_EN, default 1, SHALL mean: 1 decodes RV32M (opcode 0110011, funct7 0000001); 0 flags RV32M encodings illegal.
REQ-002 Parameter DIV_CYCLES, default 33, legal range 2..64, SHALL set the number of cycles a DIV/DIVU/REM/REMU occupies EX.
REQ-003 Parameter HAZARD_EN, default 1, SHALL mean: 1 enables load-use bubble insertion; 0 disables it.
REQ-004 Ports, in order:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  id_inst holds a valid instruction.
- id_inst  in  32  instruction in decode.
- ex_stall  in  1  EX cannot accept; hold EX registers.
- flush  in  1  kill the EX slot (branch/trap redirect).
- id_ready  out  1  decode instruction is consumed this cycle.
- ex_valid  out  1  EX slot holds an instruction.
- ex_ctrl  out  24  registered control bundle, MSB..LSB {mret, csrWrite, csrInstType[1:0], csrImmInst, ecall, ebreak, bInst, aluOp[3:0], rfWriteData[3:0], memOp[1:0], pcWrite, pcSrc, aluSrcB, aluSrcA, rfWrite, memWrite}.
- ex_rd  out  5  destination register of the EX instruction.
- ex_md_valid  out  1  EX instruction is RV32M.
- ex_md_funct3  out  3  RV32M operation select.
- ex_illegal  out  1  EX instruction is illegal.

Function
REQ-005 Decode SHALL be combinational on id_inst and SHALL cover RV32I, Zicsr, ECALL/EBREAK/MRET and RV32M, using the aluOp/rfWriteData/memOp encodings in defines.v.
REQ-006 ex_ctrl.rfWrite SHALL be forced to 0 when rd = x0.
REQ-007 Illegal: unknown opcode; funct3 not allowed for LOAD/STORE/BRANCH; SLLI/SRLI/SRAI with a wrong funct7; RV32M when MULDIV_EN=0. For an illegal instruction: ex_illegal=1, ex_valid=1, ex_ctrl=0.
REQ-008 load_use SHALL be asserted when: HAZARD_EN=1, ex_valid=1, EX holds a LOAD, ex_rd != 0, and ex_rd equals a source register the decode instruction reads (rs1 for all except LUI/AUIPC/JAL; rs2 for R, STORE, BRANCH).
REQ-009 id_ready = !ex_stall && !load_use && (state==RUN || div_cnt==0).
REQ-010 At each edge, priority order SHALL be rst, then flush, then ex_stall (hold), then load: id_valid && id_ready loads the decoded instruction; otherwise a bubble loads (ex_valid=0, ex_ctrl=0, ex_md_valid=0, ex_illegal=0).
REQ-011 Latency: an instruction accepted at edge t SHALL appear on the ex_* outputs after edge t, exactly 1 cycle.
REQ-012 FSM states: RUN and DIV_WAIT.
- RUN -> DIV_WAIT when a DIV/DIVU/REM/REMU (funct3[2]=1) loads, with div_cnt = DIV_CYCLES-1.
- In DIV_WAIT, EX registers hold and div_cnt decrements each cycle regardless of ex_stall.
- DIV_WAIT -> RUN when div_cnt==0 and the EX slot advances (load or bubble).
REQ-013 MUL/MULH/MULHSU/MULHU SHALL occupy EX for 1 cycle and SHALL stay in RUN.
REQ-014 flush SHALL clear the EX slot to a bubble, force RUN and div_cnt=0, and discard the decode instruction that cycle. This includes flush while in DIV_WAIT, and flush coincident with a divide load (the divide is dropped).
REQ-015 ex_stall with load_use both high SHALL hold EX; the bubble SHALL be inserted only on the first non-stalled cycle.

Reset
REQ-016 On rst=1 at a clock edge: ex_valid=0, ex_ctrl=0, ex_rd=0, ex_md_valid=0, ex_md_funct3=0, ex_illegal=0, state=RUN, div_cnt=0.
REQ-017 rst SHALL override flush, ex_stall and any in-progress divide.
REQ-018 id_ready SHALL equal 1 in the first cycle after reset when ex_stall=0.

Verification
REQ-019 Reset: assert rst 2 cycles with id_valid=1 -> ex_valid=0, ex_ctrl=24'h0, id_ready=1 after release.
REQ-020 ADDI x1,x0,5 (0x00500093) -> next cycle ex_valid=1, ex_rd=1, aluOp=ADD, rfWrite=1, aluSrcA=1, aluSrcB=1, ex_illegal=0.
REQ-021 Load-use: LW x5,0(x2) then ADD x6,x5,x1 -> id_ready=0 for exactly 1 cycle, then one bubble (ex_valid=0), then ADD in EX; same pattern with HAZARD_EN=0 -> no bubble.
REQ-022 DIV_CYCLES=4: DIV x3,x1,x2 -> ex_md_valid=1 for 4 consecutive cycles, id_ready=0 for 3 cycles; flush on the 2nd cycle -> ex_valid=0 next cycle, id_ready=1.
REQ-023 MULDIV_EN=0: MUL x3,x1,x2 (0x022081B3) -> ex_illegal=1, ex_valid=1, ex_ctrl=0; ADDI x0,x0,1 -> rfWrite=0.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_unit
//
// Decode-to-execute control for a small RV32 pipeline. The instruction in
// decode is decoded combinationally into a 24-bit control bundle. That bundle
// is registered into the EX slot, together with rd, the RV32M info and an
// illegal flag. The unit also inserts load-use bubbles and holds EX for the
// full latency of an iterative divide.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   id_valid      id_inst holds a valid instruction
//   id_inst       instruction in decode
//   ex_stall      EX cannot accept; hold the EX registers
//   flush         kill the EX slot (branch/trap redirect)
//   id_ready      decode instruction is consumed this cycle
//   ex_valid      EX slot holds an instruction
//   ex_ctrl       registered control bundle, MSB..LSB:
//                 {mret, csr_write, csr_inst_type[1:0], csr_imm_inst, ecall,
//                  ebreak, b_inst, alu_op[3:0], rf_write_data[3:0],
//                  mem_op[1:0], pc_write, pc_src, alu_src_b, alu_src_a,
//                  rf_write, mem_write}
//   ex_rd         destination register of the EX instruction
//   ex_md_valid   EX instruction is RV32M
//   ex_md_funct3  RV32M operation select
//   ex_illegal    EX instruction is illegal (its ex_ctrl is all zero)
//
// FSM
//   state    | meaning
//   ST_RUN   | EX advances every non-stalled cycle
//   ST_DIV   | divide occupies EX; div_cnt counts down to its last cycle
// -----------------------------------------------------------------------------
module pipe_ctrl_unit #(
  parameter int MULDIV_EN  = 1,
  parameter int DIV_CYCLES = 33,
  parameter int HAZARD_EN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        id_ready,
  output logic        ex_valid,
  output logic [23:0] ex_ctrl,
  output logic [4:0]  ex_rd,
  output logic        ex_md_valid,
  output logic [2:0]  ex_md_funct3,
  output logic        ex_illegal
);

  // opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // ALU operation select
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_COPYB = 4'd10;

  // register-file write data select
  localparam logic [3:0] RFW_ALU = 4'd0;
  localparam logic [3:0] RFW_LB  = 4'd1;
  localparam logic [3:0] RFW_LH  = 4'd2;
  localparam logic [3:0] RFW_LW  = 4'd3;
  localparam logic [3:0] RFW_LBU = 4'd4;
  localparam logic [3:0] RFW_LHU = 4'd5;
  localparam logic [3:0] RFW_PC4 = 4'd6;
  localparam logic [3:0] RFW_CSR = 4'd7;

  // memory access size
  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_B    = 2'd1;
  localparam logic [1:0] MEM_H    = 2'd2;
  localparam logic [1:0] MEM_W    = 2'd3;

  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  typedef struct packed {
    logic       mret;
    logic       csr_write;
    logic [1:0] csr_inst_type;
    logic       csr_imm_inst;
    logic       ecall;
    logic       ebreak;
    logic       b_inst;
    logic [3:0] alu_op;
    logic [3:0] rf_write_data;
    logic [1:0] mem_op;
    logic       pc_write;
    logic       pc_src;
    logic       alu_src_b;
    logic       alu_src_a;
    logic       rf_write;
    logic       mem_write;
  } ctrl_t;

  typedef enum logic {ST_RUN, ST_DIV} state_t;

  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm12;

  assign opc   = id_inst[6:0];
  assign rd    = id_inst[11:7];
  assign f3    = id_inst[14:12];
  assign rs1   = id_inst[19:15];
  assign rs2   = id_inst[24:20];
  assign f7    = id_inst[31:25];
  assign imm12 = id_inst[31:20];

  ctrl_t dc;
  logic  dec_illegal;
  logic  dec_md;
  logic  dec_load;
  logic  use_rs1;
  logic  use_rs2;

  always_comb begin
    dc          = '0;
    dec_illegal = 1'b0;
    dec_md      = 1'b0;
    dec_load    = 1'b0;
    use_rs1     = 1'b1;
    use_rs2     = 1'b0;
    case (opc)
      OPC_LUI: begin
        use_rs1      = 1'b0;
        dc.alu_op    = ALU_COPYB;
        dc.alu_src_b = 1'b1;
        dc.rf_write  = 1'b1;
      end
      OPC_AUIPC: begin
        use_rs1      = 1'b0;
        dc.alu_op    = ALU_ADD;
        dc.alu_src_b = 1'b1;
        dc.rf_write  = 1'b1;
      end
      OPC_JAL: begin
        use_rs1          = 1'b0;
        dc.pc_write      = 1'b1;
        dc.alu_src_b     = 1'b1;
        dc.rf_write_data = RFW_PC4;
        dc.rf_write      = 1'b1;
      end
      OPC_JALR: begin
        dc.pc_write      = 1'b1;
        dc.pc_src        = 1'b1;
        dc.alu_src_a     = 1'b1;
        dc.alu_src_b     = 1'b1;
        dc.rf_write_data = RFW_PC4;
        dc.rf_write      = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs2      = 1'b1;
        dc.b_inst    = 1'b1;
        dc.alu_src_a = 1'b1;
        case (f3)
          3'd0, 3'd1: dc.alu_op = ALU_SUB;
          3'd4, 3'd5: dc.alu_op = ALU_SLT;
          3'd6, 3'd7: dc.alu_op = ALU_SLTU;
          default:    dec_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_load     = 1'b1;
        dc.alu_src_a = 1'b1;
        dc.alu_src_b = 1'b1;
        dc.rf_write  = 1'b1;
        case (f3)
          3'd0: begin dc.rf_write_data = RFW_LB;  dc.mem_op = MEM_B; end
          3'd1: begin dc.rf_write_data = RFW_LH;  dc.mem_op = MEM_H; end
          3'd2: begin dc.rf_write_data = RFW_LW;  dc.mem_op = MEM_W; end
          3'd4: begin dc.rf_write_data = RFW_LBU; dc.mem_op = MEM_B; end
          3'd5: begin dc.rf_write_data = RFW_LHU; dc.mem_op = MEM_H; end
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        use_rs2      = 1'b1;
        dc.alu_src_a = 1'b1;
        dc.alu_src_b = 1'b1;
        dc.mem_write = 1'b1;
        case (f3)
          3'd0:    dc.mem_op = MEM_B;
          3'd1:    dc.mem_op = MEM_H;
          3'd2:    dc.mem_op = MEM_W;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dc.alu_src_a = 1'b1;
        dc.alu_src_b = 1'b1;
        dc.rf_write  = 1'b1;
        // imm[10] only selects SRAI; for the other ops it is immediate data
        dc.alu_op    = alu_sel(f3, (f3 == 3'd5) && f7[5]);
        if (f3 == 3'd1 && f7 != 7'b0000000) begin
          dec_illegal = 1'b1;
        end
        if (f3 == 3'd5 && f7 != 7'b0000000 && f7 != 7'b0100000) begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP: begin
        use_rs2      = 1'b1;
        dc.alu_src_a = 1'b1;
        dc.rf_write  = 1'b1;
        if (f7 == 7'b0000001) begin
          if (MULDIV_EN != 0) begin
            dec_md = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end else begin
          dc.alu_op = alu_sel(f3, f7[5]);
        end
      end
      OPC_FENCE: begin
        // single-hart, in-order memory: FENCE needs no action
      end
      OPC_SYSTEM: begin
        if (f3 == 3'd0) begin
          case (imm12)
            12'h000: dc.ecall  = 1'b1;
            12'h001: dc.ebreak = 1'b1;
            12'h302: dc.mret   = 1'b1;
            default: ;
          endcase
        end else if (f3[1:0] != 2'b00) begin
          // CSRRS/CSRRC with rs1/uimm = 0 are pure reads
          dc.csr_inst_type = f3[1:0];
          dc.csr_imm_inst  = f3[2];
          dc.csr_write     = (f3[1:0] == 2'b01) || (rs1 != 5'd0);
          dc.alu_src_a     = !f3[2];
          dc.rf_write_data = RFW_CSR;
          dc.rf_write      = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase

    if (rd == 5'd0) begin
      dc.rf_write = 1'b0;
    end
    if (dec_illegal) begin
      dc       = '0;
      dec_md   = 1'b0;
      dec_load = 1'b0;
    end
  end

  // EX registers and FSM state
  state_t     state;
  state_t     state_nxt;
  logic [5:0] div_cnt;
  logic [5:0] cnt_nxt;
  ctrl_t      ex_ctrl_q;
  logic       ex_load;
  logic       load_use;
  logic       ex_load_en;
  logic       ex_bubble;
  logic       div_busy;

  assign load_use = (HAZARD_EN != 0) && ex_valid && ex_load && (ex_rd != 5'd0) &&
                    ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd));

  assign div_busy = (state == ST_DIV) && (div_cnt != 6'd0);
  assign id_ready = !ex_stall && !load_use && !div_busy;
  assign ex_ctrl  = ex_ctrl_q;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = div_cnt;
    ex_load_en = 1'b0;
    ex_bubble  = 1'b0;
    if (flush) begin
      state_nxt = ST_RUN;
      cnt_nxt   = 6'd0;
      ex_bubble = 1'b1;
    end else if (div_busy) begin
      // the divider keeps counting even while EX is stalled
      cnt_nxt = div_cnt - 6'd1;
    end else if (ex_stall) begin
      state_nxt = state;
    end else if (id_valid && id_ready) begin
      ex_load_en = 1'b1;
      if (dec_md && f3[2]) begin
        state_nxt = ST_DIV;
        cnt_nxt   = DIV_LOAD;
      end else begin
        state_nxt = ST_RUN;
      end
    end else begin
      ex_bubble = 1'b1;
      state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      div_cnt      <= 6'd0;
      ex_valid     <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_rd        <= 5'd0;
      ex_md_valid  <= 1'b0;
      ex_md_funct3 <= 3'd0;
      ex_illegal   <= 1'b0;
      ex_load      <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= cnt_nxt;
      if (ex_bubble) begin
        ex_valid     <= 1'b0;
        ex_ctrl_q    <= '0;
        ex_rd        <= 5'd0;
        ex_md_valid  <= 1'b0;
        ex_md_funct3 <= 3'd0;
        ex_illegal   <= 1'b0;
        ex_load      <= 1'b0;
      end else if (ex_load_en) begin
        ex_valid     <= 1'b1;
        ex_ctrl_q    <= dc;
        ex_rd        <= rd;
        ex_md_valid  <= dec_md;
        ex_md_funct3 <= dec_md ? f3 : 3'd0;
        ex_illegal   <= dec_illegal;
        ex_load      <= dec_load;
      end
    end
  end

endmodule
